gemm_loop_seq: RTL and testbench

Instruction-level loop sequencer for the GEMM core; sits directly upstream of the index-compute stage. Accepts one 128-bit GEMM instruction, walks the nested loop iter_out × iter_in × [uop_bgn, uop_end), fetches each micro-op from the micro-op SRAM, and presents one {uop, iter_out, iter_in, factors} tuple per cycle to the index-compute stage over a valid/ready handshake. Full throughput: one tuple per clock when downstream never stalls.

---
 rtl/gemm_pkg.sv | 64 ++++++
 rtl/gemm_loop_cnt.sv | 53 +++++
 rtl/gemm_loop_seq.sv | 177 +++++++++++++++++
 tb/tb_gemm_loop_seq.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared GEMM instruction/micro-op field layout and types
package gemm_pkg;

    localparam int UOP_AW = 13;
    localparam int CNT_W  = 14;

    // Instruction field positions within the 128-bit word
    localparam int INSN_RESET_LSB    = 7;
    localparam int INSN_UOP_BGN_LSB  = 8;
    localparam int INSN_UOP_BGN_W    = 13;
    localparam int INSN_UOP_END_LSB  = 21;
    localparam int INSN_UOP_END_W    = 14;
    localparam int INSN_ITER_OUT_LSB = 35;
    localparam int INSN_ITER_OUT_W   = 14;
    localparam int INSN_ITER_IN_LSB  = 49;
    localparam int INSN_ITER_IN_W    = 14;
    localparam int INSN_DST_LSB      = 63;
    localparam int INSN_DST_W        = 22;
    localparam int INSN_SRC_LSB      = 85;
    localparam int INSN_SRC_W        = 22;
    localparam int INSN_WGT_LSB      = 107;
    localparam int INSN_WGT_W        = 20;

    // Micro-op field positions (consumed by the index-compute stage)
    localparam int UOP_ACC_LSB = 0;
    localparam int UOP_ACC_W   = 11;
    localparam int UOP_INP_LSB = 11;
    localparam int UOP_INP_W   = 11;
    localparam int UOP_WGT_LSB = 22;
    localparam int UOP_WGT_W   = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } seq_state_t;

    // Latched instruction; uop_bgn is widened to the internal counter width
    typedef struct packed {
        logic                  reset_reg;
        logic [CNT_W-1:0]      uop_bgn;
        logic [CNT_W-1:0]      uop_end;
        logic [CNT_W-1:0]      iter_out;
        logic [CNT_W-1:0]      iter_in;
        logic [INSN_DST_W-1:0] dst_factor;
        logic [INSN_SRC_W-1:0] src_factor;
        logic [INSN_WGT_W-1:0] wgt_factor;
    } gemm_insn_t;

    // Takes only the bits this block consumes (opcode/dep flags/bit 127 excluded)
    function automatic gemm_insn_t decode_insn(input logic [126:7] w);
        gemm_insn_t d;
        d.reset_reg  = w[INSN_RESET_LSB];
        d.uop_bgn    = {1'b0, w[INSN_UOP_BGN_LSB +: INSN_UOP_BGN_W]};
        d.uop_end    = w[INSN_UOP_END_LSB +: INSN_UOP_END_W];
        d.iter_out   = w[INSN_ITER_OUT_LSB +: INSN_ITER_OUT_W];
        d.iter_in    = w[INSN_ITER_IN_LSB +: INSN_ITER_IN_W];
        d.dst_factor = w[INSN_DST_LSB +: INSN_DST_W];
        d.src_factor = w[INSN_SRC_LSB +: INSN_SRC_W];
        d.wgt_factor = w[INSN_WGT_LSB +: INSN_WGT_W];
        return d;
    endfunction

endpackage

// File: rtl/gemm_loop_cnt.sv
// rtl/gemm_loop_cnt.sv - three-level nested loop counter (o, i, u) with last flag
module gemm_loop_cnt
    import gemm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] uop_bgn,
    input  logic [CNT_W-1:0] uop_end,
    input  logic [CNT_W-1:0] iter_out,
    input  logic [CNT_W-1:0] iter_in,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_i,
    output logic [CNT_W-1:0] cnt_u,
    output logic             last
);

    logic u_wrap;
    logic i_wrap;
    logic o_final;

    assign u_wrap  = (cnt_u == uop_end - CNT_W'(1));
    assign i_wrap  = (cnt_i == iter_in - CNT_W'(1));
    assign o_final = (cnt_o == iter_out - CNT_W'(1));
    assign last    = o_final && i_wrap && u_wrap;

    // u innermost, then i, then o; load restarts the walk at (0, 0, uop_bgn)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_o <= '0;
            cnt_i <= '0;
            cnt_u <= '0;
        end else if (load) begin
            cnt_o <= '0;
            cnt_i <= '0;
            cnt_u <= uop_bgn;
        end else if (en) begin
            if (u_wrap) begin
                cnt_u <= uop_bgn;
                if (i_wrap) begin
                    cnt_i <= '0;
                    cnt_o <= cnt_o + CNT_W'(1);
                end else begin
                    cnt_i <= cnt_i + CNT_W'(1);
                end
            end else begin
                cnt_u <= cnt_u + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gemm_loop_seq.sv
// rtl/gemm_loop_seq.sv - GEMM instruction loop sequencer feeding the index-compute stage
module gemm_loop_seq
    import gemm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              insn_valid,
    output logic              insn_ready,
    input  logic [127:0]      insn,
    output logic              uop_rd_en,
    output logic [UOP_AW-1:0] uop_rd_addr,
    input  logic [31:0]       uop_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_uop,
    output logic [13:0]       out_iter_out,
    output logic [13:0]       out_iter_in,
    output logic [21:0]       out_dst_factor,
    output logic [21:0]       out_src_factor,
    output logic [19:0]       out_wgt_factor,
    output logic              out_reset,
    output logic              out_last,
    output logic              done
);

    seq_state_t       state_q;
    seq_state_t       state_d;
    gemm_insn_t       insn_dec;
    gemm_insn_t       insn_q;
    logic             done_d;

    logic             accept;
    logic             zero_work;
    logic             adv_out;
    logic             f_can;
    logic             issue;
    logic             out_hs_last;

    logic [CNT_W-1:0] cnt_o;
    logic [CNT_W-1:0] cnt_i;
    logic [CNT_W-1:0] cnt_u;
    logic             cnt_last;

    logic             f_valid;
    logic [CNT_W-1:0] f_o;
    logic [CNT_W-1:0] f_i;
    logic             f_last;

    logic             unused_bits;

    assign unused_bits = ^{insn[6:0], insn[127], cnt_u[CNT_W-1]};

    assign insn_dec   = decode_insn(insn[126:7]);
    assign insn_ready = (state_q == ST_IDLE);
    assign accept     = insn_valid && insn_ready;
    assign zero_work  = (insn_dec.iter_out == '0) || (insn_dec.iter_in == '0) ||
                        (insn_dec.uop_end <= insn_dec.uop_bgn);

    // Output register frees when empty or handing off; F may take a new read
    // whenever it is empty or moving into the output register this cycle.
    assign adv_out     = !out_valid || out_ready;
    assign f_can       = !f_valid || adv_out;
    assign issue       = (state_q == ST_RUN) && f_can;
    assign out_hs_last = out_valid && out_ready && out_last;

    assign uop_rd_en   = issue;
    assign uop_rd_addr = cnt_u[UOP_AW-1:0];

    gemm_loop_cnt u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && !zero_work),
        .en       (issue),
        .uop_bgn  (accept ? insn_dec.uop_bgn : insn_q.uop_bgn),
        .uop_end  (insn_q.uop_end),
        .iter_out (insn_q.iter_out),
        .iter_in  (insn_q.iter_in),
        .cnt_o    (cnt_o),
        .cnt_i    (cnt_i),
        .cnt_u    (cnt_u),
        .last     (cnt_last)
    );

    // Next-state and done-pulse decode
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (zero_work) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (issue && cnt_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_hs_last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and done registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
        end
    end

    // Latch the instruction fields on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_q <= '0;
        end else if (accept) begin
            insn_q <= insn_dec;
        end
    end

    // Fetch stage metadata; the micro-op itself arrives on uop_rd_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_valid <= 1'b0;
            f_o     <= '0;
            f_i     <= '0;
            f_last  <= 1'b0;
        end else if (issue) begin
            f_valid <= 1'b1;
            f_o     <= cnt_o;
            f_i     <= cnt_i;
            f_last  <= cnt_last;
        end else if (adv_out) begin
            f_valid <= 1'b0;
        end
    end

    // Output register: loads from F when free, holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_uop        <= '0;
            out_iter_out   <= '0;
            out_iter_in    <= '0;
            out_dst_factor <= '0;
            out_src_factor <= '0;
            out_wgt_factor <= '0;
            out_reset      <= 1'b0;
            out_last       <= 1'b0;
        end else if (adv_out) begin
            out_valid <= f_valid;
            if (f_valid) begin
                out_uop        <= uop_rd_data;
                out_iter_out   <= f_o;
                out_iter_in    <= f_i;
                out_dst_factor <= insn_q.dst_factor;
                out_src_factor <= insn_q.src_factor;
                out_wgt_factor <= insn_q.wgt_factor;
                out_reset      <= insn_q.reset_reg;
                out_last       <= f_last;
            end
        end
    end

endmodule

// File: tb/tb_gemm_loop_seq.sv
// tb/tb_gemm_loop_seq.sv - scoreboard bench for gemm_loop_seq
module tb_gemm_loop_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        insn_valid = 1'b0;
    logic        insn_ready;
    logic [127:0] insn = '0;
    logic        uop_rd_en;
    logic [12:0] uop_rd_addr;
    logic [31:0] uop_rd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_uop;
    logic [13:0] out_iter_out;
    logic [13:0] out_iter_in;
    logic [21:0] out_dst_factor;
    logic [21:0] out_src_factor;
    logic [19:0] out_wgt_factor;
    logic        out_reset;
    logic        out_last;
    logic        done;

    typedef struct packed {
        logic [31:0] uop;
        logic [13:0] o;
        logic [13:0] i;
        logic        last;
        logic [21:0] dst;
        logic [21:0] src;
        logic [19:0] wgt;
        logic        rst;
    } tuple_t;

    tuple_t      sb[$];
    tuple_t      cur;
    tuple_t      held;
    tuple_t      exp_t;
    logic [31:0] mem [0:8191];
    logic [12:0] rd_log[$];
    int          done_cycs[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_valid = -1;
    int first_rd = -1;
    int valid_cnt = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    bit prev_stall = 0;
    bit rnd_ready = 0;

    gemm_loop_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .insn_valid     (insn_valid),
        .insn_ready     (insn_ready),
        .insn           (insn),
        .uop_rd_en      (uop_rd_en),
        .uop_rd_addr    (uop_rd_addr),
        .uop_rd_data    (uop_rd_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_uop        (out_uop),
        .out_iter_out   (out_iter_out),
        .out_iter_in    (out_iter_in),
        .out_dst_factor (out_dst_factor),
        .out_src_factor (out_src_factor),
        .out_wgt_factor (out_wgt_factor),
        .out_reset      (out_reset),
        .out_last       (out_last),
        .done           (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: registered read, holds data when not reading
    always @(posedge clk) if (uop_rd_en) uop_rd_data <= mem[uop_rd_addr];

    always @(posedge clk) begin
        #1;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    assign cur = '{uop: out_uop, o: out_iter_out, i: out_iter_in, last: out_last,
                   dst: out_dst_factor, src: out_src_factor, wgt: out_wgt_factor,
                   rst: out_reset};

    // Monitor: scoreboard pop on handshake, stall stability, read/done logging
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || cur !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b uop=%h o=%0d i=%0d, expected valid=1 uop=%h o=%0d i=%0d",
                             out_valid, cur.uop, cur.o, cur.i, held.uop, held.o, held.i);
                end
            end
            if (uop_rd_en) begin
                rd_log.push_back(uop_rd_addr);
                if (first_rd < 0) first_rd = cyc;
            end
            if (out_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cycs.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL tuple_unexpected: got uop=%h o=%0d i=%0d last=%b, expected no tuple",
                             cur.uop, cur.o, cur.i, cur.last);
                end else begin
                    exp_t = sb.pop_front();
                    if (cur !== exp_t) begin
                        errors++;
                        $display("FAIL tuple: got uop=%h o=%0d i=%0d last=%b dst=%h src=%h wgt=%h rst=%b, expected uop=%h o=%0d i=%0d last=%b dst=%h src=%h wgt=%h rst=%b",
                                 cur.uop, cur.o, cur.i, cur.last, cur.dst, cur.src, cur.wgt, cur.rst,
                                 exp_t.uop, exp_t.o, exp_t.i, exp_t.last, exp_t.dst, exp_t.src, exp_t.wgt, exp_t.rst);
                    end
                end
                hs_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            held = cur;
        end
    end

    function automatic logic [127:0] make_insn(input int bgn, input int en, input int no, input int ni,
                                               input logic [21:0] dst, input logic [21:0] src,
                                               input logic [19:0] wgt, input logic rst);
        logic [127:0] w;
        w          = '0;
        w[2:0]     = 3'd2;
        w[6:3]     = 4'hA;
        w[7]       = rst;
        w[20:8]    = 13'(bgn);
        w[34:21]   = 14'(en);
        w[48:35]   = 14'(no);
        w[62:49]   = 14'(ni);
        w[84:63]   = dst;
        w[106:85]  = src;
        w[126:107] = wgt;
        w[127]     = 1'b1;
        return w;
    endfunction

    task automatic push_expected(input int bgn, input int en, input int no, input int ni,
                                 input logic [21:0] dst, input logic [21:0] src,
                                 input logic [19:0] wgt, input logic rst);
        tuple_t t;
        for (int o = 0; o < no; o++)
            for (int i = 0; i < ni; i++)
                for (int u = bgn; u < en; u++) begin
                    t.uop  = mem[u];
                    t.o    = 14'(o);
                    t.i    = 14'(i);
                    t.last = (o == no - 1) && (i == ni - 1) && (u == en - 1);
                    t.dst  = dst;
                    t.src  = src;
                    t.wgt  = wgt;
                    t.rst  = rst;
                    sb.push_back(t);
                end
    endtask

    task automatic clear_stats();
        first_valid = -1;
        first_rd    = -1;
        valid_cnt   = 0;
        hs_cnt      = 0;
        rd_log.delete();
        done_cycs.delete();
    endtask

    // Offer an instruction until accepted; acc is the cycle count just after the accept edge
    task automatic send_insn(input logic [127:0] w, output int acc);
        bit seen;
        seen = 0;
        acc  = -1;
        @(posedge clk); #1;
        insn       = w;
        insn_valid = 1'b1;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk);
            if (insn_ready) seen = 1;
        end
        if (seen) begin
            @(posedge clk); #1;
            acc = cyc;
        end
        insn_valid = 1'b0;
    endtask

    task automatic wait_done(input int n_target, input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            if (done_cnt >= n_target) ok = 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (insn_ready !== 1'b1) begin errors++; $display("FAIL reset_insn_ready: got %b, expected 1", insn_ready); end
        checks++;
        if (uop_rd_en !== 1'b0 || uop_rd_addr !== 13'd0) begin
            errors++; $display("FAIL reset_rd: got en=%b addr=%0d, expected 0/0", uop_rd_en, uop_rd_addr);
        end
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_valid_done: got %b/%b, expected 0/0", out_valid, done);
        end
        checks++;
        if (cur !== '0) begin errors++; $display("FAIL reset_tuple: got %h, expected 0", cur); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int acc; bit ok; int n;
        mem[5] = 32'hDEADBEEF;
        clear_stats();
        push_expected(5, 6, 1, 1, 22'h12345, 22'h2ABCD, 20'hF00D, 1'b1);
        n = done_cnt;
        send_insn(make_insn(5, 6, 1, 1, 22'h12345, 22'h2ABCD, 20'hF00D, 1'b1), acc);
        wait_done(n + 1, 50, ok);
        checks++;
        if (!ok || acc < 0) begin errors++; $display("FAIL single_done: got timeout, expected done"); end
        else begin
            checks++;
            if (first_rd != acc) begin errors++; $display("FAIL single_rd_cycle: got %0d, expected %0d", first_rd, acc); end
            checks++;
            if (first_valid != acc + 2) begin errors++; $display("FAIL single_latency: got %0d, expected %0d", first_valid, acc + 2); end
            checks++;
            if (done_cycs[0] != acc + 3) begin errors++; $display("FAIL single_done_cycle: got %0d, expected %0d", done_cycs[0], acc + 3); end
        end
        checks++;
        if (hs_cnt != 1 || sb.size() != 0) begin errors++; $display("FAIL single_count: got hs=%0d left=%0d, expected 1/0", hs_cnt, sb.size()); end
        checks++;
        if (rd_log.size() != 1 || rd_log[0] != 13'd5) begin errors++; $display("FAIL single_reads: got %0d reads, expected one read of 5", rd_log.size()); end
    endtask

    task automatic test_nested(input bit rnd);
        int acc; bit ok; int n;
        mem[0] = 32'h1111_0000;
        mem[1] = 32'h2222_0001;
        clear_stats();
        push_expected(0, 2, 2, 3, 22'h3FFFFF, 22'h000001, 20'h80001, 1'b0);
        rnd_ready = rnd;
        n = done_cnt;
        send_insn(make_insn(0, 2, 2, 3, 22'h3FFFFF, 22'h000001, 20'h80001, 1'b0), acc);
        wait_done(n + 1, 400, ok);
        rnd_ready = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL nested_done: got timeout, expected done (rnd=%0d)", rnd); end
        checks++;
        if (hs_cnt != 12 || sb.size() != 0) begin errors++; $display("FAIL nested_count: got hs=%0d left=%0d, expected 12/0", hs_cnt, sb.size()); end
        if (!rnd && ok) begin
            checks++;
            if (valid_cnt != 12 || done_cycs[0] != first_valid + 12) begin
                errors++; $display("FAIL nested_throughput: got valid=%0d done_at=%0d, expected 12/%0d", valid_cnt, done_cycs[0], first_valid + 12);
            end
        end
    endtask

    task automatic test_zero_work();
        int acc; bit ok; int n;
        for (int c = 0; c < 2; c++) begin
            clear_stats();
            n = done_cnt;
            send_insn((c == 0) ? make_insn(0, 4, 2, 0, 22'h1, 22'h2, 20'h3, 1'b0)
                               : make_insn(7, 7, 1, 1, 22'h1, 22'h2, 20'h3, 1'b0), acc);
            wait_done(n + 1, 10, ok);
            repeat (4) @(negedge clk);
            checks++;
            if (!ok || done_cycs.size() != 1 || done_cycs[0] != acc) begin
                errors++; $display("FAIL zero_done_%0d: got ok=%0d pulses=%0d, expected one pulse at %0d", c, ok, done_cycs.size(), acc);
            end
            checks++;
            if (rd_log.size() != 0 || valid_cnt != 0) begin
                errors++; $display("FAIL zero_activity_%0d: got reads=%0d valid=%0d, expected 0/0", c, rd_log.size(), valid_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc; bit ok; int n;
        for (int u = 10; u < 15; u++) mem[u] = 32'hA000_0000 + u;
        mem[20] = 32'hCAFE_0020;
        mem[21] = 32'hCAFE_0021;
        clear_stats();
        push_expected(10, 15, 3, 2, 22'h55, 22'h66, 20'h77, 1'b1);
        send_insn(make_insn(10, 15, 3, 2, 22'h55, 22'h66, 20'h77, 1'b1), acc);
        for (int k = 0; k < 200 && hs_cnt < 4; k++) @(negedge clk);
        checks++;
        if (hs_cnt < 4) begin errors++; $display("FAIL rstmid_progress: got hs=%0d, expected 4", hs_cnt); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || uop_rd_en !== 1'b0 || done !== 1'b0 || insn_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_ctrl: got valid=%b rd=%b done=%b ready=%b, expected 0/0/0/1", out_valid, uop_rd_en, done, insn_ready);
        end
        checks++;
        if (cur !== '0) begin errors++; $display("FAIL rstmid_tuple: got %h, expected 0", cur); end
        sb.delete();
        n = done_cnt;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != n) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses, expected 0", done_cnt - n); end
        clear_stats();
        push_expected(20, 22, 1, 1, 22'h9, 22'h8, 20'h7, 1'b0);
        send_insn(make_insn(20, 22, 1, 1, 22'h9, 22'h8, 20'h7, 1'b0), acc);
        wait_done(n + 1, 50, ok);
        checks++;
        if (!ok || hs_cnt != 2 || sb.size() != 0 || rd_log.size() == 0 || rd_log[0] != 13'd20) begin
            errors++; $display("FAIL rstmid_rerun: got ok=%0d hs=%0d reads=%0d, expected 1/2 from addr 20", ok, hs_cnt, rd_log.size());
        end
    endtask

    task automatic test_max_range();
        int acc; bit ok; int n;
        mem[8190] = 32'h0BAD_1FFE;
        mem[8191] = 32'h0BAD_1FFF;
        clear_stats();
        push_expected(8190, 8192, 1, 1, 22'h1, 22'h1, 20'h1, 1'b0);
        n = done_cnt;
        send_insn(make_insn(8190, 8192, 1, 1, 22'h1, 22'h1, 20'h1, 1'b0), acc);
        wait_done(n + 1, 50, ok);
        checks++;
        if (!ok || rd_log.size() != 2) begin errors++; $display("FAIL maxrange_reads: got ok=%0d reads=%0d, expected 1/2", ok, rd_log.size()); end
        else begin
            checks++;
            if (rd_log[0] != 13'd8190 || rd_log[1] != 13'd8191) begin
                errors++; $display("FAIL maxrange_addr: got %0d,%0d, expected 8190,8191", rd_log[0], rd_log[1]);
            end
        end
        checks++;
        if (sb.size() != 0 || hs_cnt != 2) begin errors++; $display("FAIL maxrange_count: got hs=%0d left=%0d, expected 2/0", hs_cnt, sb.size()); end
    endtask

    task automatic test_back_to_back();
        int acc1; int acc2; bit ok; int n;
        for (int u = 30; u < 33; u++) mem[u] = 32'hB000_0000 + u;
        mem[40] = 32'hB000_0040;
        clear_stats();
        push_expected(30, 33, 1, 1, 22'h11, 22'h22, 20'h33, 1'b0);
        push_expected(40, 41, 2, 1, 22'h44, 22'h55, 20'h66, 1'b1);
        n = done_cnt;
        send_insn(make_insn(30, 33, 1, 1, 22'h11, 22'h22, 20'h33, 1'b0), acc1);
        send_insn(make_insn(40, 41, 2, 1, 22'h44, 22'h55, 20'h66, 1'b1), acc2);
        wait_done(n + 2, 100, ok);
        checks++;
        if (!ok || done_cycs.size() != 2) begin errors++; $display("FAIL b2b_done: got ok=%0d pulses=%0d, expected 1/2", ok, done_cycs.size()); end
        else begin
            checks++;
            if (acc2 != done_cycs[0] + 1) begin errors++; $display("FAIL b2b_accept: got %0d, expected %0d", acc2, done_cycs[0] + 1); end
        end
        checks++;
        if (hs_cnt != 5 || sb.size() != 0) begin errors++; $display("FAIL b2b_count: got hs=%0d left=%0d, expected 5/0", hs_cnt, sb.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_nested(1'b0);
        test_nested(1'b1);
        test_zero_work();
        test_reset_mid();
        test_max_range();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
